ram_sweep_ctrl: RTL and testbench
=================================

RAM_SWEEP_CTRL -- requirements
Module: ram_sweep_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, RAM address width; depth DEPTH = 2^ADDR_W.
REQ-002 Parameter DATA_W, default 8, RAM data width.
REQ-003 Parameter RD_DIV, default 10_000_000, sys_clk cycles per address step in paced read (200 ms at 50 MHz); legal range >= 2.
REQ-004 Parameter ERR_W, default 16, error counter width.
REQ-005 Parameter SEED, default 8'hA5 (zero-extended or truncated to DATA_W), constant for pattern 3.
REQ-006 Port list, in order:
  - sys_clk  in  1  sole clock; one clock; reset is synchronous and active-high.
  - sys_rst  in  1  synchronous active-high reset.
  - key_wr  in  1  one-cycle pulse; start a write sweep.
  - key_rd  in  1  one-cycle pulse; start a paced read sweep.
  - key_chk  in  1  one-cycle pulse; start a full-speed verify sweep.
  - pattern_sel  in  2  data pattern; sampled only on accepted key_wr.
  - rd_data  in  DATA_W  RAM read data, valid 1 cycle after rd_en/addr.
  - wr_en  out  1  RAM write enable.
  - rd_en  out  1  RAM read enable.
  - addr  out  ADDR_W  RAM address.
  - wr_data  out  DATA_W  pattern(addr) while wr_en=1, else 0.
  - busy  out  1  high in any state other than IDLE.
  - done  out  1  one-cycle pulse at completion of a WRITE or VERIFY sweep.
  - pass  out  1  last verify had zero mismatches; valid with done after VERIFY.
  - err_cnt  out  ERR_W  mismatch count of the current/last verify, saturating.
  - err_addr  out  ADDR_W  address of the first mismatch of the last verify.

Function
REQ-007 FSM states: IDLE, WRITE, READ, VERIFY, DRAIN.
REQ-008 Patterns: 0 = addr zero-extended/truncated to DATA_W; 1 = bitwise NOT of pattern 0; 2 = 0x55.. when addr[0]=0, 0xAA.. when addr[0]=1; 3 = SEED.
REQ-009 Key priority on simultaneous pulses: key_wr > key_chk > key_rd.
REQ-010 key_wr in any state: addr<=0, latch pattern_sel, enter WRITE next cycle; aborts READ/VERIFY/DRAIN without done.
REQ-011 WRITE: wr_en=1, addr increments by 1 each cycle from 0; after the cycle with addr=DEPTH-1, wr_en<=0, addr<=0, done pulses, go IDLE; exactly DEPTH write cycles.
REQ-012 key_rd and key_chk are ignored while in WRITE.
REQ-013 key_rd in IDLE/READ/VERIFY/DRAIN: addr<=0, pace counter<=0, enter READ; rd_en=1 throughout READ.
REQ-014 READ: pace counter counts 0..RD_DIV-1; at RD_DIV-1 addr increments, wrapping DEPTH-1 -> 0; runs until another accepted key; never pulses done.
REQ-015 key_chk in IDLE/READ/VERIFY/DRAIN: addr<=0, err_cnt<=0, enter VERIFY.
REQ-016 VERIFY: rd_en=1, addr increments every cycle 0..DEPTH-1, then DRAIN (rd_en=0, addr<=0) for one cycle, then IDLE.
REQ-017 Compare: each rd_data is compared with pattern(addr registered one cycle earlier) using the latched pattern; compares cover exactly DEPTH addresses, the last one in DRAIN.
REQ-018 On mismatch: err_cnt increments, holding at 2^ERR_W-1; err_addr captured only on the first mismatch of a verify.
REQ-019 done pulses the cycle after DRAIN; pass=(err_cnt==0) registered at that same edge, held until the next verify starts (cleared to 0 on key_chk).
REQ-020 The pattern used for verify is the one latched by the last key_wr; pattern 0 if no write since reset.

Reset
REQ-021 sys_rst=1 at a clock edge: state IDLE, wr_en=0, rd_en=0, addr=0, wr_data=0, busy=0, done=0, pass=0, err_cnt=0, err_addr=0, pace counter=0, latched pattern=0.
REQ-022 Reset mid-sweep aborts with no done pulse; keys sampled during reset are ignored.

Structure
REQ-023 Shared package ram_sweep_pkg holds the state enum, pattern-select encoding and pattern function.
REQ-024 Sub-module ram_sweep_pace (parametrised RD_DIV tick counter with synchronous clear) is instantiated once.

Verification (ADDR_W=4, DATA_W=8, RD_DIV=4, ERR_W=4, behavioural 1-cycle RAM)
REQ-025 key_wr, pattern_sel=0 -> wr_en high 16 cycles, addr 0..15, wr_data=addr, done 1 cycle after, RAM[i]=i.
REQ-026 After REQ-025, key_chk -> rd_en 16 cycles, DRAIN, done, pass=1, err_cnt=0.
REQ-027 Write pattern 1, corrupt RAM[5]=0x00 and RAM[9]=0x00, key_chk -> err_cnt=2, err_addr=5, pass=0.
REQ-028 key_rd -> addr steps every 4 cycles, 15 -> 0 wrap observed, no done; key_wr mid-READ -> WRITE next cycle, rd_en=0.
REQ-029 key_wr and key_chk same cycle -> WRITE; key_chk during WRITE ignored; sys_rst mid-VERIFY -> all outputs reset values, no done.
REQ-030 Pattern 3 written, all 16 words corrupted, key_chk -> err_cnt saturates at 15.

Source files
------------

// File: rtl/ram_sweep_pkg.sv
// Shared types and the data-pattern generator for the RAM sweep controller.
package ram_sweep_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WRITE  = 3'd1,
      ST_READ   = 3'd2,
      ST_VERIFY = 3'd3,
      ST_DRAIN  = 3'd4
   } sweep_state_e;

   typedef enum logic [1:0] {
      PAT_ADDR    = 2'd0,
      PAT_INV     = 2'd1,
      PAT_CHECKER = 2'd2,
      PAT_SEED    = 2'd3
   } pat_sel_e;

   // Produces a 64-bit pattern word; callers truncate to their data width,
   // which yields zero-extension/truncation of the address or seed.
   function automatic logic [63:0] pattern_word(input pat_sel_e sel,
                                                input logic [63:0] addr_w,
                                                input logic [63:0] seed_w);
      logic [63:0] word_s;
      case (sel)
         PAT_ADDR:    word_s = addr_w;
         PAT_INV:     word_s = ~addr_w;
         PAT_CHECKER: word_s = addr_w[0] ? {32{2'b10}} : {32{2'b01}};
         PAT_SEED:    word_s = seed_w;
         default:     word_s = 64'h0;
      endcase
      return word_s;
   endfunction

endpackage

// File: rtl/ram_sweep_pace.sv
// Free-running 0..RD_DIV-1 counter; tick marks the terminal count.
module ram_sweep_pace #(
   parameter int unsigned RD_DIV = 10_000_000
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int unsigned CNT_W = (RD_DIV > 1) ? $clog2(RD_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RD_DIV - 1);

   logic [CNT_W-1:0] cnt_r;

   // Pace counter: cleared on request, otherwise counts while enabled and wraps.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (clr) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (en) begin
         if (cnt_r == CNT_MAX) begin
            cnt_r <= {CNT_W{1'b0}};
         end else begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign tick = (cnt_r == CNT_MAX);

endmodule

// File: rtl/ram_sweep_ctrl.sv
// RAM sweep controller: pattern write, paced read-out and full-speed verify.
module ram_sweep_ctrl
   import ram_sweep_pkg::*;
#(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned RD_DIV = 10_000_000,
   parameter int unsigned ERR_W  = 16,
   parameter logic [7:0]  SEED   = 8'hA5
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              key_wr,
   input  logic              key_rd,
   input  logic              key_chk,
   input  logic [1:0]        pattern_sel,
   input  logic [DATA_W-1:0] rd_data,
   output logic              wr_en,
   output logic              rd_en,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ERR_W-1:0]  err_cnt,
   output logic [ADDR_W-1:0] err_addr
);

   localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
   localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};

   sweep_state_e      state_r, state_nxt_s;
   pat_sel_e          pat_r, pat_nxt_s;
   logic [ADDR_W-1:0] addr_d_r;
   logic              cmp_vld_r, err_seen_r;

   logic              chk_acc_s, rd_acc_s, any_acc_s;
   logic              pace_tick_s, pace_clr_s, pace_en_s;
   logic [DATA_W-1:0] exp_cmp_s;
   logic              mismatch_s;
   logic [ERR_W-1:0]  err_upd_s;

   logic              wr_en_nxt_s, rd_en_nxt_s, done_nxt_s, pass_nxt_s, err_seen_nxt_s;
   logic [ADDR_W-1:0] addr_nxt_s, err_addr_nxt_s;
   logic [DATA_W-1:0] wr_data_nxt_s;
   logic [ERR_W-1:0]  err_cnt_nxt_s;

   // key_wr always wins; check and read keys are dead while writing.
   assign chk_acc_s = key_chk && !key_wr && (state_r != ST_WRITE);
   assign rd_acc_s  = key_rd && !key_wr && !key_chk && (state_r != ST_WRITE);
   assign any_acc_s = key_wr || chk_acc_s || rd_acc_s;

   // Read data returns one cycle after the address, so compare against the delayed address.
   assign exp_cmp_s  = DATA_W'(pattern_word(pat_r, 64'(addr_d_r), 64'(SEED)));
   assign mismatch_s = cmp_vld_r && (rd_data != exp_cmp_s);
   assign err_upd_s  = (mismatch_s && (err_cnt != ERR_MAX)) ? (err_cnt + ERR_W'(1)) : err_cnt;

   ram_sweep_pace #(.RD_DIV(RD_DIV)) u_pace (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .clr     (pace_clr_s),
      .en      (pace_en_s),
      .tick    (pace_tick_s)
   );

   // State register.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic: accepted keys first, then sweep progress.
   always_comb begin
      state_nxt_s = state_r;
      if (key_wr) begin
         state_nxt_s = ST_WRITE;
      end else if (chk_acc_s) begin
         state_nxt_s = ST_VERIFY;
      end else if (rd_acc_s) begin
         state_nxt_s = ST_READ;
      end else begin
         case (state_r)
            ST_WRITE:  state_nxt_s = (addr == ADDR_LAST) ? ST_IDLE : ST_WRITE;
            ST_VERIFY: state_nxt_s = (addr == ADDR_LAST) ? ST_DRAIN : ST_VERIFY;
            ST_DRAIN:  state_nxt_s = ST_IDLE;
            default:   state_nxt_s = state_r;
         endcase
      end
   end

   // Output logic: next values for every registered output and verify bookkeeping.
   always_comb begin
      addr_nxt_s     = addr;
      wr_en_nxt_s    = 1'b0;
      rd_en_nxt_s    = 1'b0;
      done_nxt_s     = 1'b0;
      pass_nxt_s     = pass;
      pat_nxt_s      = pat_r;
      err_cnt_nxt_s  = err_upd_s;
      err_addr_nxt_s = (mismatch_s && !err_seen_r) ? addr_d_r : err_addr;
      err_seen_nxt_s = err_seen_r || mismatch_s;
      pace_clr_s     = 1'b1;
      pace_en_s      = 1'b0;
      if (key_wr) begin
         addr_nxt_s  = {ADDR_W{1'b0}};
         pat_nxt_s   = pat_sel_e'(pattern_sel);
         wr_en_nxt_s = 1'b1;
      end else if (chk_acc_s) begin
         addr_nxt_s     = {ADDR_W{1'b0}};
         rd_en_nxt_s    = 1'b1;
         err_cnt_nxt_s  = {ERR_W{1'b0}};
         err_addr_nxt_s = {ADDR_W{1'b0}};
         err_seen_nxt_s = 1'b0;
         pass_nxt_s     = 1'b0;
      end else if (rd_acc_s) begin
         addr_nxt_s  = {ADDR_W{1'b0}};
         rd_en_nxt_s = 1'b1;
      end else begin
         case (state_r)
            ST_WRITE: begin
               if (addr == ADDR_LAST) begin
                  addr_nxt_s = {ADDR_W{1'b0}};
                  done_nxt_s = 1'b1;
               end else begin
                  addr_nxt_s  = addr + ADDR_W'(1);
                  wr_en_nxt_s = 1'b1;
               end
            end
            ST_READ: begin
               rd_en_nxt_s = 1'b1;
               pace_clr_s  = 1'b0;
               pace_en_s   = 1'b1;
               addr_nxt_s  = pace_tick_s ? (addr + ADDR_W'(1)) : addr;
            end
            ST_VERIFY: begin
               if (addr == ADDR_LAST) begin
                  addr_nxt_s = {ADDR_W{1'b0}};
               end else begin
                  addr_nxt_s  = addr + ADDR_W'(1);
                  rd_en_nxt_s = 1'b1;
               end
            end
            ST_DRAIN: begin
               done_nxt_s = 1'b1;
               pass_nxt_s = (err_upd_s == {ERR_W{1'b0}});
            end
            default: begin
               addr_nxt_s = addr;
            end
         endcase
      end
      if (wr_en_nxt_s) begin
         wr_data_nxt_s = DATA_W'(pattern_word(pat_nxt_s, 64'(addr_nxt_s), 64'(SEED)));
      end else begin
         wr_data_nxt_s = {DATA_W{1'b0}};
      end
   end

   // Output and bookkeeping registers.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         wr_en      <= 1'b0;
         rd_en      <= 1'b0;
         addr       <= {ADDR_W{1'b0}};
         wr_data    <= {DATA_W{1'b0}};
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_cnt    <= {ERR_W{1'b0}};
         err_addr   <= {ADDR_W{1'b0}};
         pat_r      <= PAT_ADDR;
         addr_d_r   <= {ADDR_W{1'b0}};
         cmp_vld_r  <= 1'b0;
         err_seen_r <= 1'b0;
      end else begin
         wr_en      <= wr_en_nxt_s;
         rd_en      <= rd_en_nxt_s;
         addr       <= addr_nxt_s;
         wr_data    <= wr_data_nxt_s;
         busy       <= (state_nxt_s != ST_IDLE);
         done       <= done_nxt_s;
         pass       <= pass_nxt_s;
         err_cnt    <= err_cnt_nxt_s;
         err_addr   <= err_addr_nxt_s;
         pat_r      <= pat_nxt_s;
         addr_d_r   <= addr;
         cmp_vld_r  <= (state_r == ST_VERIFY) && !any_acc_s;
         err_seen_r <= err_seen_nxt_s;
      end
   end

endmodule

// File: tb/tb_ram_sweep_ctrl.sv
// Self-checking bench for ram_sweep_ctrl with a behavioural 1-cycle RAM.
module tb_ram_sweep_ctrl;

   localparam int AW = 4;
   localparam int DW = 8;
   localparam int EW = 4;
   localparam int DEPTH = 16;

   logic          sys_clk = 1'b0;
   logic          sys_rst = 1'b1;
   logic          key_wr = 1'b0, key_rd = 1'b0, key_chk = 1'b0;
   logic [1:0]    pattern_sel = 2'd0;
   logic [DW-1:0] rd_data;
   logic          wr_en, rd_en, busy, done, pass;
   logic [AW-1:0] addr, err_addr;
   logic [DW-1:0] wr_data;
   logic [EW-1:0] err_cnt;

   logic [DW-1:0] mem [DEPTH];
   logic          poke_en = 1'b0;
   logic [AW-1:0] poke_addr = 4'd0;
   logic [DW-1:0] poke_val = 8'd0;

   logic [DW-1:0] exp_mem [DEPTH];
   int            exp_sel = 0;
   int            vectors = 0;
   int            miscompares = 0;

   ram_sweep_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_DIV(4), .ERR_W(EW), .SEED(8'hA5)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .key_wr(key_wr), .key_rd(key_rd), .key_chk(key_chk),
      .pattern_sel(pattern_sel), .rd_data(rd_data), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
      .wr_data(wr_data), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .err_addr(err_addr)
   );

   always #5 sys_clk = ~sys_clk;

   // Behavioural synchronous RAM with a bench-side poke port for corruption.
   always @(posedge sys_clk) begin
      if (wr_en) mem[addr] <= wr_data;
      else if (poke_en) mem[poke_addr] <= poke_val;
      if (rd_en) rd_data <= mem[addr];
   end

   function automatic logic [7:0] ref_pat(int sel, int a);
      case (sel)
         0:       ref_pat = 8'(a);
         1:       ref_pat = 8'(255 - a);
         2:       ref_pat = (a % 2 == 1) ? 8'hAA : 8'h55;
         default: ref_pat = 8'hA5;
      endcase
   endfunction

   task automatic poke(input int a, input logic [7:0] v);
      poke_en = 1'b1; poke_addr = 4'(a); poke_val = v;
      @(negedge sys_clk);
      poke_en = 1'b0;
      exp_mem[a] = v;
   endtask

   task automatic test_reset;
      sys_rst = 1'b1;
      repeat (3) @(negedge sys_clk);
      vectors++;
      if ({wr_en, rd_en, addr, wr_data, busy, done, pass, err_cnt, err_addr} !== 26'd0) begin
         miscompares++;
         $display("FAIL reset_outputs got wr=%b rd=%b addr=%0d wd=%h busy=%b done=%b pass=%b ec=%0d ea=%0d want all 0",
                  wr_en, rd_en, addr, wr_data, busy, done, pass, err_cnt, err_addr);
      end
      sys_rst = 1'b0;
      @(negedge sys_clk);
      vectors++;
      if ({busy, done, wr_en, rd_en} !== 4'd0) begin
         miscompares++;
         $display("FAIL post_reset_idle got busy=%b done=%b wr=%b rd=%b want 0", busy, done, wr_en, rd_en);
      end
   endtask

   // Full write sweep: checks each write cycle, the done pulse and final RAM contents.
   task automatic test_write(input int sel);
      pattern_sel = 2'(sel);
      key_wr = 1'b1;
      @(negedge sys_clk);
      key_wr = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         vectors++;
         if ({wr_en, rd_en, busy, done, addr, wr_data} !== {1'b1, 1'b0, 1'b1, 1'b0, 4'(i), ref_pat(sel, i)}) begin
            miscompares++;
            $display("FAIL write_cycle i=%0d got wr=%b rd=%b busy=%b done=%b addr=%0d wd=%h want 1 0 1 0 %0d %h",
                     i, wr_en, rd_en, busy, done, addr, wr_data, i, ref_pat(sel, i));
         end
         @(negedge sys_clk);
      end
      vectors++;
      if ({wr_en, done, busy, addr, wr_data} !== {1'b0, 1'b1, 1'b0, 4'd0, 8'd0}) begin
         miscompares++;
         $display("FAIL write_done got wr=%b done=%b busy=%b addr=%0d wd=%h want 0 1 0 0 00", wr_en, done, busy, addr, wr_data);
      end
      exp_sel = sel;
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = ref_pat(sel, i);
      @(negedge sys_clk);
      vectors++;
      if (done !== 1'b0) begin
         miscompares++;
         $display("FAIL write_done_width got done=%b want 0", done);
      end
      for (int i = 0; i < DEPTH; i++) begin
         vectors++;
         if (mem[i] !== exp_mem[i]) begin
            miscompares++;
            $display("FAIL ram_content a=%0d got %h want %h", i, mem[i], exp_mem[i]);
         end
      end
   endtask

   // Verify sweep: expected errors computed by scanning the expected RAM image.
   task automatic test_verify;
      int errs = 0;
      int first = -1;
      int sat;
      for (int i = 0; i < DEPTH; i++) begin
         if (exp_mem[i] !== ref_pat(exp_sel, i)) begin
            errs++;
            if (first < 0) first = i;
         end
      end
      sat = (errs > 15) ? 15 : errs;
      key_chk = 1'b1;
      @(negedge sys_clk);
      key_chk = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         vectors++;
         if ({rd_en, wr_en, busy, done, pass, addr} !== {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'(i)}) begin
            miscompares++;
            $display("FAIL verify_cycle i=%0d got rd=%b wr=%b busy=%b done=%b pass=%b addr=%0d want 1 0 1 0 0 %0d",
                     i, rd_en, wr_en, busy, done, pass, addr, i);
         end
         @(negedge sys_clk);
      end
      vectors++;
      if ({rd_en, busy, done, addr} !== {1'b0, 1'b1, 1'b0, 4'd0}) begin
         miscompares++;
         $display("FAIL verify_drain got rd=%b busy=%b done=%b addr=%0d want 0 1 0 0", rd_en, busy, done, addr);
      end
      @(negedge sys_clk);
      vectors++;
      if ({done, busy, pass, err_cnt} !== {1'b1, 1'b0, (errs == 0), 4'(sat)}) begin
         miscompares++;
         $display("FAIL verify_result got done=%b busy=%b pass=%b err_cnt=%0d want 1 0 %b %0d",
                  done, busy, pass, err_cnt, (errs == 0), sat);
      end
      if (errs > 0) begin
         vectors++;
         if (err_addr !== 4'(first)) begin
            miscompares++;
            $display("FAIL verify_err_addr got %0d want %0d", err_addr, first);
         end
      end
      @(negedge sys_clk);
      vectors++;
      if ({done, pass, err_cnt} !== {1'b0, (errs == 0), 4'(sat)}) begin
         miscompares++;
         $display("FAIL verify_hold got done=%b pass=%b err_cnt=%0d want 0 %b %0d", done, pass, err_cnt, (errs == 0), sat);
      end
   endtask

   task automatic test_corrupt_fixed;
      test_write(1);
      poke(5, 8'h00);
      poke(9, 8'h00);
      test_verify();
   endtask

   task automatic test_corrupt_random;
      for (int r = 0; r < 3; r++) begin
         test_write(int'($urandom_range(0, 3)));
         repeat (int'($urandom_range(0, 3))) poke(int'($urandom_range(0, 15)), 8'($urandom));
         test_verify();
      end
   endtask

   task automatic test_saturate;
      test_write(3);
      for (int i = 0; i < DEPTH; i++) poke(i, 8'(i * 3 + 1));
      test_verify();
   endtask

   // Paced read: address holds 4 cycles per step, wraps 15->0, never pulses done; then key_wr aborts.
   task automatic test_read;
      key_rd = 1'b1;
      @(negedge sys_clk);
      key_rd = 1'b0;
      for (int k = 0; k < 70; k++) begin
         vectors++;
         if ({rd_en, wr_en, busy, done, addr} !== {1'b1, 1'b0, 1'b1, 1'b0, 4'((k / 4) % 16)}) begin
            miscompares++;
            $display("FAIL read_pace k=%0d got rd=%b wr=%b busy=%b done=%b addr=%0d want 1 0 1 0 %0d",
                     k, rd_en, wr_en, busy, done, addr, (k / 4) % 16);
         end
         @(negedge sys_clk);
      end
      test_write(int'($urandom_range(0, 3)));
   endtask

   // Simultaneous keys resolve to write; key_chk during write is ignored.
   task automatic test_back_to_back;
      int sel = int'($urandom_range(0, 3));
      pattern_sel = 2'(sel);
      key_wr = 1'b1; key_chk = 1'b1; key_rd = 1'b1;
      @(negedge sys_clk);
      key_wr = 1'b0; key_chk = 1'b0; key_rd = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         vectors++;
         if ({wr_en, rd_en, addr, wr_data} !== {1'b1, 1'b0, 4'(i), ref_pat(sel, i)}) begin
            miscompares++;
            $display("FAIL prio_write i=%0d got wr=%b rd=%b addr=%0d wd=%h want 1 0 %0d %h",
                     i, wr_en, rd_en, addr, wr_data, i, ref_pat(sel, i));
         end
         key_chk = (i == 4) || (i == 11);
         key_rd  = (i == 7);
         @(negedge sys_clk);
         key_chk = 1'b0; key_rd = 1'b0;
      end
      vectors++;
      if ({done, wr_en, rd_en} !== 3'b100) begin
         miscompares++;
         $display("FAIL prio_done got done=%b wr=%b rd=%b want 1 0 0", done, wr_en, rd_en);
      end
      exp_sel = sel;
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = ref_pat(sel, i);
      @(negedge sys_clk);
      test_verify();
   endtask

   // Reset in the middle of a verify: everything clears, no done, latched pattern returns to 0.
   task automatic test_reset_mid_verify;
      test_write(int'($urandom_range(1, 3)));
      key_chk = 1'b1;
      @(negedge sys_clk);
      key_chk = 1'b0;
      repeat (6) @(negedge sys_clk);
      sys_rst = 1'b1; key_wr = 1'b1;
      @(negedge sys_clk);
      vectors++;
      if ({wr_en, rd_en, addr, wr_data, busy, done, pass, err_cnt, err_addr} !== 26'd0) begin
         miscompares++;
         $display("FAIL mid_reset got wr=%b rd=%b addr=%0d wd=%h busy=%b done=%b pass=%b ec=%0d ea=%0d want all 0",
                  wr_en, rd_en, addr, wr_data, busy, done, pass, err_cnt, err_addr);
      end
      @(negedge sys_clk);
      sys_rst = 1'b0; key_wr = 1'b0;
      for (int k = 0; k < 20; k++) begin
         vectors++;
         if ({busy, done, wr_en, rd_en} !== 4'd0) begin
            miscompares++;
            $display("FAIL after_reset k=%0d got busy=%b done=%b wr=%b rd=%b want 0", k, busy, done, wr_en, rd_en);
         end
         @(negedge sys_clk);
      end
      exp_sel = 0;
      test_verify();
   endtask

   initial begin
      test_reset();
      test_write(0);
      test_verify();
      test_corrupt_fixed();
      test_read();
      test_verify();
      test_back_to_back();
      test_corrupt_random();
      test_saturate();
      test_reset_mid_verify();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
